// File: rtl/plab3_mem_cache_domain_arb.sv
// rtl/plab3_mem_cache_domain_arb.sv - round-robin two-domain arbiter in front of a blocking cache
module plab3_mem_cache_domain_arb #(
    parameter int p_req_nbits  = 77,
    parameter int p_resp_nbits = 45
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic [p_req_nbits-1:0]  req0_msg,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    output logic [p_resp_nbits-1:0] resp0_msg,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,

    input  logic [p_req_nbits-1:0]  req1_msg,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    output logic [p_resp_nbits-1:0] resp1_msg,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,

    output logic [p_req_nbits-1:0]  cachereq_msg,
    output logic                    cachereq_val,
    input  logic                    cachereq_rdy,
    input  logic [p_resp_nbits-1:0] cacheresp_msg,
    input  logic                    cacheresp_val,
    output logic                    cacheresp_rdy,

    output logic                    domain
);

    typedef enum logic [1:0] {IDLE, SWITCH, SEND, WAIT} state_t;

    state_t                 state, state_nxt;
    logic                   grant;
    logic                   prio;
    logic                   domain_q;
    logic [p_req_nbits-1:0] msg_q;
    logic                   winner;
    logic                   accept;
    logic                   resp_fire;

    // On a tie prio picks the port; otherwise the single valid port wins.
    assign winner = (req0_val && req1_val) ? prio : req1_val;

    assign domain       = domain_q;
    assign cachereq_msg = msg_q;

    // Every val/rdy output is gated by reset so a mid-transaction reset
    // silences the interface in the same instant the state is cleared.
    always_comb begin
        state_nxt     = state;
        req0_rdy      = 1'b0;
        req1_rdy      = 1'b0;
        resp0_val     = 1'b0;
        resp1_val     = 1'b0;
        resp0_msg     = '0;
        resp1_msg     = '0;
        cachereq_val  = 1'b0;
        cacheresp_rdy = 1'b0;
        accept        = 1'b0;
        resp_fire     = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE: begin
                    if (req0_val || req1_val) begin
                        req0_rdy  = !winner;
                        req1_rdy  = winner;
                        accept    = 1'b1;
                        state_nxt = (winner == domain_q) ? SEND : SWITCH;
                    end
                end
                SWITCH: state_nxt = SEND;
                SEND: begin
                    cachereq_val = 1'b1;
                    if (cachereq_rdy) state_nxt = WAIT;
                end
                WAIT: begin
                    if (grant) begin
                        resp1_val     = cacheresp_val;
                        resp1_msg     = cacheresp_msg;
                        cacheresp_rdy = resp1_rdy;
                    end else begin
                        resp0_val     = cacheresp_val;
                        resp0_msg     = cacheresp_msg;
                        cacheresp_rdy = resp0_rdy;
                    end
                    if (cacheresp_val && cacheresp_rdy) begin
                        resp_fire = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= 1'b0;
            prio     <= 1'b0;
            domain_q <= 1'b0;
            msg_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant <= winner;
                msg_q <= winner ? req1_msg : req0_msg;
            end
            if (state == SWITCH) domain_q <= grant;
            if (resp_fire) prio <= ~grant;
        end
    end

endmodule

// File: tb/tb_plab3_mem_cache_domain_arb.sv
// tb/tb_plab3_mem_cache_domain_arb.sv - scoreboard bench for the two-domain cache arbiter
module tb_plab3_mem_cache_domain_arb;

    logic        clk;
    logic        reset;
    logic [76:0] req0_msg, req1_msg, cachereq_msg;
    logic        req0_val, req0_rdy, req1_val, req1_rdy;
    logic [44:0] resp0_msg, resp1_msg, cacheresp_msg;
    logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic        cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
    logic        domain;

    plab3_mem_cache_domain_arb #(.p_req_nbits(77), .p_resp_nbits(45)) dut (
        .clk(clk), .reset(reset),
        .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .cachereq_msg(cachereq_msg), .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cacheresp_msg(cacheresp_msg), .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .domain(domain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [76:0] q_send0[$], q_send1[$];
    logic [44:0] exp_resp0[$], exp_resp1[$];
    bit          q_order[$];

    bit          tb_prio, tb_dom, inflight, inflight_port, pend, req_seen, exp_dom;
    logic [44:0] pend_msg;
    logic [76:0] acc_msg;
    int          cyc, acc_cyc, exp_lat, stall, rhold, stall_seen, hold_seen;

    function automatic logic [76:0] mk_req(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] data);
        return {3'd1, op, addr, 2'd0, data};
    endfunction

    // Reference cache: echoes type/opaque/len and returns data xor addr.
    function automatic logic [44:0] cache_resp(input logic [76:0] m);
        return {m[76:74], m[73:66], m[33:32], m[31:0] ^ m[65:34]};
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_req_rdy"}, {req1_rdy, req0_rdy}, 2'b00);
        check({tag, "_resp_val"}, {resp1_val, resp0_val}, 2'b00);
        check({tag, "_cache_vr"}, {cachereq_val, cacheresp_rdy}, 2'b00);
        check({tag, "_domain"}, domain, 1'b0);
        check({tag, "_msg_q"}, cachereq_msg, 77'd0);
    endtask

    task automatic model_clear();
        q_send0.delete(); q_send1.delete(); exp_resp0.delete(); exp_resp1.delete();
        q_order.delete();
        tb_prio = 0; tb_dom = 0; inflight = 0; pend = 0; stall = 0; rhold = 0;
    endtask

    task automatic cycle();
        bit          busy, p;
        logic [76:0] m;
        logic [44:0] e;
        busy = inflight;
        req0_val = q_send0.size() > 0;
        req0_msg = req0_val ? q_send0[0] : '0;
        req1_val = q_send1.size() > 0;
        req1_msg = req1_val ? q_send1[0] : '0;
        cachereq_rdy  = (stall == 0);
        cacheresp_val = pend;
        cacheresp_msg = pend ? pend_msg : '0;
        resp0_rdy = 1'b1;
        resp1_rdy = (rhold == 0);
        #1;
        if (cacheresp_val) begin
            p = inflight_port;
            check("resp_val_grant", p ? resp1_val : resp0_val, 1'b1);
            check("resp_val_other", p ? resp0_val : resp1_val, 1'b0);
            if (p ? resp1_rdy : resp0_rdy) begin
                check("cacheresp_rdy", cacheresp_rdy, 1'b1);
                check("sb_nonempty", p ? exp_resp1.size() : exp_resp0.size(), 1);
                e = p ? exp_resp1.pop_front() : exp_resp0.pop_front();
                check("resp_msg", p ? resp1_msg : resp0_msg, e);
                pend = 0; inflight = 0; tb_prio = ~p;
            end else begin
                check("cacheresp_rdy_hold", cacheresp_rdy, 1'b0);
                rhold--; hold_seen++;
            end
        end
        if (cachereq_val) begin
            if (!req_seen) begin
                check("req_latency", cyc - acc_cyc, exp_lat);
                req_seen = 1;
            end
            check("req_domain", domain, exp_dom);
            check("req_msg", cachereq_msg, acc_msg);
            if (cachereq_rdy) begin
                pend = 1; pend_msg = cache_resp(cachereq_msg);
            end else begin
                stall--; stall_seen++;
            end
        end
        if (busy) begin
            check("rdy_busy", {req1_rdy, req0_rdy}, 2'b00);
        end else if (req0_val || req1_val) begin
            p = (req0_val && req1_val) ? tb_prio : req1_val;
            check("grant_rdy", {req1_rdy, req0_rdy}, p ? 2'b10 : 2'b01);
            if (q_order.size() > 0) check("grant_order", p, q_order.pop_front());
            m = p ? q_send1.pop_front() : q_send0.pop_front();
            if (p) exp_resp1.push_back(cache_resp(m));
            else   exp_resp0.push_back(cache_resp(m));
            acc_msg = m; acc_cyc = cyc; req_seen = 0;
            exp_lat = (p == tb_dom) ? 1 : 2;
            tb_dom = p; exp_dom = p; inflight = 1; inflight_port = p;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int budget, input bit stop_on_pend);
        int n;
        n = 0;
        while ((q_send0.size() > 0 || q_send1.size() > 0 || inflight) && n < budget) begin
            if (stop_on_pend && pend) break;
            cycle();
            n++;
        end
        check("run_in_budget", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        req0_val = 0; req1_val = 0; cacheresp_val = 0; cachereq_rdy = 0;
        resp0_rdy = 0; resp1_rdy = 0; req0_msg = '0; req1_msg = '0; cacheresp_msg = '0;
        #1;
        check_quiet("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        cyc = 0; acc_cyc = 0; exp_lat = 0; stall_seen = 0; hold_seen = 0;
        req_seen = 0; exp_dom = 0; inflight_port = 0; pend_msg = '0; acc_msg = '0;
        @(negedge clk);
        do_reset();

        // 1: lone port 0, same domain, no bubble
        q_send0.push_back(mk_req(8'h01, 32'h0000_0100, 32'hdead_beef));
        run(40, 0);
        check("t1_domain", domain, 1'b0);

        // 2: port 1 forces a switch bubble
        q_send1.push_back(mk_req(8'h02, 32'h0000_0200, 32'h1234_5678));
        run(40, 0);
        check("t2_domain", domain, 1'b1);

        // 3: both ports busy from reset alternate 0,1,0,1
        do_reset();
        for (int i = 0; i < 2; i++) begin
            q_send0.push_back(mk_req(8'h10 + 8'(i), 32'h1000 + 32'(i * 4), 32'(i)));
            q_send1.push_back(mk_req(8'h20 + 8'(i), 32'h2000 + 32'(i * 4), 32'hff00 + 32'(i)));
        end
        q_order = '{0, 1, 0, 1};
        run(80, 0);
        check("t3_order_done", q_order.size(), 0);

        // 4: cache stalls three cycles in SEND
        stall = 3; stall_seen = 0;
        q_send0.push_back(mk_req(8'h30, 32'h3000, 32'hcafe_f00d));
        q_send1.push_back(mk_req(8'h31, 32'h3100, 32'h0bad_c0de));
        q_order = '{0, 1};
        run(60, 0);
        check("t4_stall_cycles", stall_seen, 3);

        // 5: port 1 holds off its response for two cycles
        rhold = 2; hold_seen = 0;
        q_send1.push_back(mk_req(8'h40, 32'h4000, 32'h5555_aaaa));
        run(40, 0);
        check("t5_hold_cycles", hold_seen, 2);

        // 6: reset lands while a response is pending in WAIT
        rhold = 1000;
        q_send1.push_back(mk_req(8'h50, 32'h5000, 32'h7777_8888));
        run(40, 1);
        cacheresp_val = 1'b1; cacheresp_msg = pend_msg; resp1_rdy = 1'b0;
        req0_val = 1'b1; req0_msg = mk_req(8'h51, 32'h5100, 32'h1);
        #1;
        check("t6_wait_resp1_val", resp1_val, 1'b1);
        check("t6_wait_domain", domain, 1'b1);
        reset = 1'b0;
        #1;
        check_quiet("t6_abort");
        do_reset();
        q_send0.push_back(mk_req(8'h60, 32'h6000, 32'h0000_0060));
        q_send1.push_back(mk_req(8'h61, 32'h6100, 32'h0000_0061));
        q_order = '{0, 1};
        run(60, 0);
        check("t6_order_done", q_order.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
